// File: rtl/lbm_rng_pkg.sv
// Shared types and constants for the Gaussian-RNG scheduler slice.
package lbm_rng_pkg;

  localparam int W_RNG = 56;
  localparam logic [W_RNG-1:0] DEFAULT_SEED = 56'h00_1234_5678_9ABC;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } rng_state_t;

  typedef logic [W_RNG-1:0] rng_word_t;

  // Successor of a round-robin index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: double-width masked priority encoder.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [2*N-1:0] mask_s;
  logic [2*N-1:0] masked_s;
  logic           hit_s;

  // Lowest set bit at or above ptr in {req, req}; the upper copy handles wrap-around.
  always_comb begin
    mask_s     = {(2*N){1'b1}} << ptr;
    masked_s   = {req, req} & mask_s;
    gnt_idx    = {PW{1'b0}};
    gnt_any    = 1'b0;
    hit_s      = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      hit_s   = masked_s[i] & ~gnt_any;
      gnt_idx = hit_s ? PW'(i % N) : gnt_idx;
      gnt_any = gnt_any | masked_s[i];
    end
    gnt_onehot = gnt_any ? (N'(1) << gnt_idx) : {N{1'b0}};
  end

endmodule

// File: rtl/gaus_rng_sched.sv
// Seeds, warms up and time-shares one LFSR Gaussian generator among N_REQ units.
module gaus_rng_sched #(
  parameter int          N_REQ        = 4,
  parameter int          W            = 56,
  parameter int          WARMUP       = 64,
  parameter logic [W-1:0] DEFAULT_SEED = W'(lbm_rng_pkg::DEFAULT_SEED)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [W-1:0]     seed_in,
  input  logic             seed_load,
  input  logic [W-1:0]     rng_sample,
  output logic             rng_reset_n,
  output logic [W-1:0]     rng_seed,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [W-1:0]     rand_out,
  output logic             rand_valid,
  output logic             ready
);

  import lbm_rng_pkg::*;

  localparam int PW  = $clog2(N_REQ);
  localparam int WCW = 10;

  rng_state_t       state_r;
  rng_state_t       next_state_s;
  logic [W-1:0]     seed_r;
  logic             seed_cnt_r;
  logic [WCW-1:0]   warm_cnt_r;
  logic [PW-1:0]    rr_ptr_r;
  logic             rng_reset_n_r;
  logic             ready_r;
  logic [N_REQ-1:0] gnt_r;
  logic             rand_valid_r;
  logic [W-1:0]     rand_out_r;

  logic [N_REQ-1:0] win_onehot_s;
  logic [PW-1:0]    win_idx_s;
  logic             win_any_s;
  logic             arb_en_s;
  logic             rng_reset_n_nxt_s;
  logic             ready_nxt_s;
  logic [PW-1:0]    ptr_nxt_s;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .req        (req),
    .ptr        (rr_ptr_r),
    .gnt_onehot (win_onehot_s),
    .gnt_idx    (win_idx_s),
    .gnt_any    (win_any_s)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= lbm_rng_pkg::SEED;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a seed load restarts the sequence from any state.
  always_comb begin
    next_state_s = state_r;
    if (seed_load) begin
      next_state_s = lbm_rng_pkg::SEED;
    end else begin
      case (state_r)
        lbm_rng_pkg::SEED:   next_state_s = seed_cnt_r ? lbm_rng_pkg::WARMUP : lbm_rng_pkg::SEED;
        lbm_rng_pkg::WARMUP: next_state_s = (warm_cnt_r == WCW'(WARMUP - 1)) ? lbm_rng_pkg::RUN
                                                                             : lbm_rng_pkg::WARMUP;
        lbm_rng_pkg::RUN:    next_state_s = lbm_rng_pkg::RUN;
        default:             next_state_s = lbm_rng_pkg::SEED;
      endcase
    end
  end

  // Output decode: next values for the registered outputs and arbitration enable.
  always_comb begin
    rng_reset_n_nxt_s = 1'b0;
    ready_nxt_s       = 1'b0;
    case (next_state_s)
      lbm_rng_pkg::SEED:   rng_reset_n_nxt_s = 1'b0;
      lbm_rng_pkg::WARMUP: rng_reset_n_nxt_s = 1'b1;
      lbm_rng_pkg::RUN: begin
        rng_reset_n_nxt_s = 1'b1;
        ready_nxt_s       = 1'b1;
      end
      default:             rng_reset_n_nxt_s = 1'b0;
    endcase
    arb_en_s  = (state_r == lbm_rng_pkg::RUN) && !seed_load;
    ptr_nxt_s = PW'(rr_next(int'(win_idx_s), N_REQ));
  end

  // Seed capture and SEED/WARMUP phase counters.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      seed_r     <= DEFAULT_SEED;
      seed_cnt_r <= 1'b0;
      warm_cnt_r <= {WCW{1'b0}};
    end else begin
      if (seed_load) begin
        seed_r <= seed_in;
      end else begin
        seed_r <= seed_r;
      end
      if (!seed_load && state_r == lbm_rng_pkg::SEED) begin
        seed_cnt_r <= seed_cnt_r + 1'b1;
      end else begin
        seed_cnt_r <= 1'b0;
      end
      if (!seed_load && state_r == lbm_rng_pkg::WARMUP) begin
        warm_cnt_r <= warm_cnt_r + WCW'(1);
      end else begin
        warm_cnt_r <= {WCW{1'b0}};
      end
    end
  end

  // Generator control and status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rng_reset_n_r <= 1'b0;
      ready_r       <= 1'b0;
    end else begin
      rng_reset_n_r <= rng_reset_n_nxt_s;
      ready_r       <= ready_nxt_s;
    end
  end

  // Grant and sample delivery; rand_out keeps its last value on idle cycles.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gnt_r        <= {N_REQ{1'b0}};
      rand_valid_r <= 1'b0;
      rand_out_r   <= {W{1'b0}};
      rr_ptr_r     <= {PW{1'b0}};
    end else if (arb_en_s && win_any_s) begin
      gnt_r        <= win_onehot_s;
      rand_valid_r <= 1'b1;
      rand_out_r   <= rng_sample;
      rr_ptr_r     <= ptr_nxt_s;
    end else begin
      gnt_r        <= {N_REQ{1'b0}};
      rand_valid_r <= 1'b0;
      rand_out_r   <= rand_out_r;
      rr_ptr_r     <= rr_ptr_r;
    end
  end

  assign rng_reset_n = rng_reset_n_r;
  assign rng_seed    = seed_r;
  assign ready       = ready_r;
  assign gnt         = gnt_r;
  assign rand_valid  = rand_valid_r;
  assign rand_out    = rand_out_r;

endmodule

// File: tb/tb_gaus_rng_sched.sv
// Self-checking bench for gaus_rng_sched: randomized samples/requests vs a cycle-age reference model.
module tb_gaus_rng_sched;

  localparam int N      = 4;
  localparam int WW     = 56;
  localparam int WUP    = 64;
  localparam int RUN_AT = 2 + WUP;
  localparam logic [WW-1:0] DEF_SEED = 56'h00_1234_5678_9ABC;

  logic          Clk;
  logic          Reset;
  logic [WW-1:0] seed_in;
  logic          seed_load;
  logic [WW-1:0] rng_sample;
  logic          rng_reset_n;
  logic [WW-1:0] rng_seed;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [WW-1:0] rand_out;
  logic          rand_valid;
  logic          ready;

  int n_checks;
  int n_fail;

  // Reference model: phase is just the cycle age since reset release or the last seed pulse.
  int            m_age;
  logic [WW-1:0] m_seed;
  int            m_ptr;
  logic [N-1:0]  m_gnt;
  logic          m_valid;
  logic [WW-1:0] m_out;
  logic [WW-1:0] last_sample;

  gaus_rng_sched #(
    .N_REQ        (N),
    .W            (WW),
    .WARMUP       (WUP),
    .DEFAULT_SEED (DEF_SEED)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .seed_in     (seed_in),
    .seed_load   (seed_load),
    .rng_sample  (rng_sample),
    .rng_reset_n (rng_reset_n),
    .rng_seed    (rng_seed),
    .req         (req),
    .gnt         (gnt),
    .rand_out    (rand_out),
    .rand_valid  (rand_valid),
    .ready       (ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_age   = 0;
    m_seed  = DEF_SEED;
    m_ptr   = 0;
    m_gnt   = '0;
    m_valid = 1'b0;
    m_out   = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic l, input logic [WW-1:0] s,
                            input logic [WW-1:0] smp);
    bit running;
    int idx;
    running = (m_age >= RUN_AT);
    m_gnt   = '0;
    m_valid = 1'b0;
    if (l) begin
      m_age  = 0;
      m_seed = s;
    end else begin
      if (m_age < 1000000) m_age++;
      if (running) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (r[idx] && !m_valid) begin
            m_gnt[idx] = 1'b1;
            m_valid    = 1'b1;
            m_out      = smp;
            m_ptr      = (idx + 1) % N;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs plus a fresh generator word, advance the model, land on the next negedge.
  task automatic cycle(input logic [N-1:0] r, input logic l, input logic [WW-1:0] s);
    logic [63:0] rnd;
    rnd         = {$urandom(), $urandom()};
    req         = r;
    seed_load   = l;
    seed_in     = s;
    rng_sample  = rnd[WW-1:0];
    last_sample = rnd[WW-1:0];
    model_step(r, l, s, rnd[WW-1:0]);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    @(negedge Clk);
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_checks++; if (rand_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", rand_valid); end
    n_checks++; if (rand_out !== 56'h0) begin n_fail++; $display("FAIL reset_out got=%h want=0", rand_out); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", ready); end
    n_checks++; if (rng_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_rngrst got=%b want=0", rng_reset_n); end
    n_checks++; if (rng_seed !== DEF_SEED) begin n_fail++; $display("FAIL reset_seed got=%h want=%h", rng_seed, DEF_SEED); end
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_startup();
    logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n_checks++; if (rng_reset_n !== 1'b0) begin n_fail++; $display("FAIL start_rngrst c=0 got=%b want=0", rng_reset_n); end
    for (int c = 1; c <= RUN_AT + 5; c++) begin
      cycle(4'b1111, 1'b0, '0);
      n_checks++;
      if (rng_reset_n !== (c >= 2)) begin n_fail++; $display("FAIL start_rngrst c=%0d got=%b want=%b", c, rng_reset_n, c >= 2); end
      n_checks++;
      if (ready !== (c >= RUN_AT)) begin n_fail++; $display("FAIL start_ready c=%0d got=%b want=%b", c, ready, c >= RUN_AT); end
      n_checks++;
      if (c > RUN_AT) begin
        if (gnt !== seq[c - RUN_AT - 1]) begin n_fail++; $display("FAIL start_gnt c=%0d got=%b want=%b", c, gnt, seq[c - RUN_AT - 1]); end
      end else begin
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL start_gnt c=%0d got=%b want=0000", c, gnt); end
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0100, 1'b0, '0);
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt i=%0d got=%b want=0100", i, gnt); end
      n_checks++; if (rand_out !== last_sample) begin n_fail++; $display("FAIL single_out i=%0d got=%h want=%h", i, rand_out, last_sample); end
      n_checks++; if (rand_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid i=%0d got=%b want=1", i, rand_valid); end
    end
    cycle(4'b0000, 1'b0, '0);
    n_checks++; if (gnt !== 4'b0000 || rand_valid !== 1'b0) begin n_fail++; $display("FAIL idle_gnt got=%b/%b want=0000/0", gnt, rand_valid); end
    n_checks++; if (rand_out !== m_out) begin n_fail++; $display("FAIL idle_hold got=%h want=%h", rand_out, m_out); end
  endtask

  task automatic test_alternate();
    logic [N-1:0] want;
    cycle(4'b0010, 1'b0, '0);
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL alt_pre got=%b want=0010", gnt); end
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1010, 1'b0, '0);
      want = (i % 2 == 0) ? 4'b1000 : 4'b0010;
      n_checks++; if (gnt !== want) begin n_fail++; $display("FAIL alt_gnt i=%0d got=%b want=%b", i, gnt, want); end
    end
  endtask

  task automatic test_reseed_run();
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, '0);
    cycle(4'b1111, 1'b1, 56'h1);
    n_checks++; if (gnt !== 4'b0000 || rand_valid !== 1'b0) begin n_fail++; $display("FAIL rsd_clear got=%b/%b want=0000/0", gnt, rand_valid); end
    n_checks++; if (rng_seed !== 56'h1) begin n_fail++; $display("FAIL rsd_seed got=%h want=1", rng_seed); end
    for (int k = 1; k <= RUN_AT + 4; k++) begin
      cycle(4'b1111, 1'b0, '0);
      n_checks++; if (rng_reset_n !== (k >= 2)) begin n_fail++; $display("FAIL rsd_rngrst k=%0d got=%b want=%b", k, rng_reset_n, k >= 2); end
      n_checks++; if (ready !== (k >= RUN_AT)) begin n_fail++; $display("FAIL rsd_ready k=%0d got=%b want=%b", k, ready, k >= RUN_AT); end
      n_checks++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rsd_gnt k=%0d got=%b want=%b", k, gnt, m_gnt); end
      n_checks++; if (rand_out !== m_out) begin n_fail++; $display("FAIL rsd_out k=%0d got=%h want=%h", k, rand_out, m_out); end
    end
  endtask

  task automatic test_reseed_warmup();
    logic [63:0] rs;
    cycle(4'b0000, 1'b1, 56'hAB);
    for (int k = 1; k <= 32; k++) cycle(4'b0100, 1'b0, '0);
    rs = {$urandom(), $urandom()};
    cycle(4'b0100, 1'b1, rs[WW-1:0]);
    n_checks++; if (rng_seed !== rs[WW-1:0]) begin n_fail++; $display("FAIL wrsd_seed got=%h want=%h", rng_seed, rs[WW-1:0]); end
    for (int k = 1; k <= RUN_AT + 1; k++) begin
      cycle(4'b0100, 1'b0, '0);
      n_checks++; if (ready !== (k >= RUN_AT)) begin n_fail++; $display("FAIL wrsd_ready k=%0d got=%b want=%b", k, ready, k >= RUN_AT); end
      n_checks++; if (rng_reset_n !== (k >= 2)) begin n_fail++; $display("FAIL wrsd_rngrst k=%0d got=%b want=%b", k, rng_reset_n, k >= 2); end
    end
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wrsd_gnt got=%b want=0100", gnt); end
  endtask

  task automatic test_async_reset();
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL areset_gnt got=%b want=0000", gnt); end
    n_checks++; if (rand_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b want=0", rand_valid); end
    n_checks++; if (rand_out !== 56'h0) begin n_fail++; $display("FAIL areset_out got=%h want=0", rand_out); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready got=%b want=0", ready); end
    n_checks++; if (rng_seed !== DEF_SEED) begin n_fail++; $display("FAIL areset_seed got=%h want=%h", rng_seed, DEF_SEED); end
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [63:0] rs;
    logic        ld;
    for (int i = 0; i < 400; i++) begin
      rs = {$urandom(), $urandom()};
      ld = ($urandom_range(0, 99) == 0);
      cycle(N'($urandom_range(0, 15)), ld, rs[WW-1:0]);
      n_checks++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rnd_gnt i=%0d got=%b want=%b", i, gnt, m_gnt); end
      n_checks++; if (rand_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid i=%0d got=%b want=%b", i, rand_valid, m_valid); end
      n_checks++; if (rand_out !== m_out) begin n_fail++; $display("FAIL rnd_out i=%0d got=%h want=%h", i, rand_out, m_out); end
      n_checks++; if (ready !== (m_age >= RUN_AT)) begin n_fail++; $display("FAIL rnd_ready i=%0d got=%b want=%b", i, ready, m_age >= RUN_AT); end
      n_checks++; if (rng_reset_n !== (m_age >= 2)) begin n_fail++; $display("FAIL rnd_rngrst i=%0d got=%b want=%b", i, rng_reset_n, m_age >= 2); end
      n_checks++; if (rng_seed !== m_seed) begin n_fail++; $display("FAIL rnd_seed i=%0d got=%h want=%h", i, rng_seed, m_seed); end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    Reset      = 1'b0;
    req        = '0;
    seed_load  = 1'b0;
    seed_in    = '0;
    rng_sample = '0;
    model_reset();
    test_reset();
    test_startup();
    test_single();
    test_alternate();
    test_reseed_run();
    test_reseed_warmup();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
